// File: rtl/atree_reduce_ctrl.sv
// Time-multiplexed sum reduction: NUM_ADDERS shared adders fold NUM_INPUTS
// operands in place over log2(NUM_INPUTS) passes, with valid/ready on both sides.
module atree_reduce_ctrl #(
  parameter int IN_WIDTH   = 32,
  parameter int NUM_INPUTS = 8,
  parameter int NUM_ADDERS = 2,
  localparam int OUT_WIDTH = IN_WIDTH + $clog2(NUM_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_INPUTS*IN_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           out_sum,
  output logic                           busy
);

  localparam int PASSES = $clog2(NUM_INPUTS);
  localparam int PW     = $clog2(PASSES + 1);
  localparam int CW     = $clog2(NUM_INPUTS);
  localparam int IDXW   = $clog2(NUM_INPUTS);
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pass_q;
  logic [CW-1:0]         chunk_q;
  logic [OUT_WIDTH-1:0]  opbuf [NUM_INPUTS];
  logic [OUT_WIDTH-1:0]  sum_q;

  int                    pairs;
  logic                  last_chunk;
  logic                  finishing;
  logic [NUM_ADDERS-1:0] pair_en;
  logic [IDXW-1:0]       pair_dst [NUM_ADDERS];
  logic [OUT_WIDTH-1:0]  pair_sum [NUM_ADDERS];

  // Adder level: decode which pairs this chunk folds and their sums.
  // The extra REDUCE cycle with pass == LAST_PASS only publishes opbuf[0].
  always_comb begin
    pairs      = (NUM_INPUTS >> pass_q) >> 1;
    last_chunk = ((int'(chunk_q) + 1) * NUM_ADDERS) >= pairs;
    finishing  = (pass_q == LAST_PASS);
    for (int k = 0; k < NUM_ADDERS; k++) begin
      int j;
      logic [IDXW-1:0] lo;
      logic [IDXW-1:0] hi;
      j  = int'(chunk_q) * NUM_ADDERS + k;
      lo = '0;
      hi = '0;
      pair_en[k] = (state_q == REDUCE) && !finishing && (j < pairs);
      if (pair_en[k]) begin
        lo          = IDXW'(2 * j);
        hi          = IDXW'(2 * j + 1);
        pair_dst[k] = IDXW'(j);
        pair_sum[k] = opbuf[lo] + opbuf[hi];
      end else begin
        pair_dst[k] = '0;
        pair_sum[k] = '0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = REDUCE;
        else          state_d = IDLE;
      end
      REDUCE: begin
        if (finishing) state_d = DONE;
        else           state_d = REDUCE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == REDUCE) || (state_q == DONE);
    out_sum   = sum_q;
  end

  // Pass/chunk sequencing and the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q  <= '0;
      chunk_q <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          pass_q  <= '0;
          chunk_q <= '0;
        end
        REDUCE: begin
          if (finishing) begin
            sum_q <= opbuf[0];
          end else if (last_chunk) begin
            pass_q  <= pass_q + PW'(1);
            chunk_q <= '0;
          end else begin
            chunk_q <= chunk_q + CW'(1);
          end
        end
        default: begin
          pass_q  <= pass_q;
          chunk_q <= chunk_q;
        end
      endcase
    end
  end

  // Operand buffer: loaded on accept, folded in place during REDUCE.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      for (int n = 0; n < NUM_INPUTS; n++) begin
        opbuf[n] <= OUT_WIDTH'(in_data[n*IN_WIDTH +: IN_WIDTH]);
      end
    end else if (state_q == REDUCE) begin
      for (int k = 0; k < NUM_ADDERS; k++) begin
        if (pair_en[k]) opbuf[pair_dst[k]] <= pair_sum[k];
      end
    end
  end

endmodule

// File: tb/tb_atree_reduce_ctrl.sv
// Bench for atree_reduce_ctrl: three instances (2, 1 and 4 adders) share the
// input side; results are checked against a plain-sum reference model.
module tb_atree_reduce_ctrl;

  localparam int IW = 8;
  localparam int NI = 8;
  localparam int OW = IW + $clog2(NI);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [NI*IW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic [2:0]    in_ready, out_valid, busy;
  logic [OW-1:0] out_sum [3];

  int total_checks = 0;
  int passed_checks = 0;
  int adders [3] = '{2, 1, 4};

  always #5 clk = ~clk;

  atree_reduce_ctrl #(.IN_WIDTH(IW), .NUM_INPUTS(NI), .NUM_ADDERS(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_sum(out_sum[0]), .busy(busy[0]));
  atree_reduce_ctrl #(.IN_WIDTH(IW), .NUM_INPUTS(NI), .NUM_ADDERS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_sum(out_sum[1]), .busy(busy[1]));
  atree_reduce_ctrl #(.IN_WIDTH(IW), .NUM_INPUTS(NI), .NUM_ADDERS(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_data(in_data), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_sum(out_sum[2]), .busy(busy[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_sum(input logic [NI*IW-1:0] v);
    int s = 0;
    for (int n = 0; n < NI; n++) s += int'(v[n*IW +: IW]);
    return s;
  endfunction

  // Latency from accepting edge to out_valid: reduce cycles plus the DONE edge.
  function automatic int model_latency(input int na);
    int c = 0;
    for (int p = 0; p < $clog2(NI); p++) c += ((NI >> (p + 1)) + na - 1) / na;
    return c + 1;
  endfunction

  function automatic logic [NI*IW-1:0] seq_vec();
    logic [NI*IW-1:0] v;
    for (int n = 0; n < NI; n++) v[n*IW +: IW] = IW'(n + 1);
    return v;
  endfunction

  function automatic logic [NI*IW-1:0] fill_vec(input logic [IW-1:0] b);
    logic [NI*IW-1:0] v;
    for (int n = 0; n < NI; n++) v[n*IW +: IW] = b;
    return v;
  endfunction

  function automatic logic [NI*IW-1:0] rand_vec();
    logic [NI*IW-1:0] v;
    for (int n = 0; n < NI; n++) v[n*IW +: IW] = IW'($urandom_range(0, 255));
    return v;
  endfunction

  // Present a vector for one accepting edge; returns cycles until dut0 out_valid (0 = timeout).
  task automatic send_and_wait(input logic [NI*IW-1:0] v, output int lat);
    in_data  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (out_valid[0]) begin
        lat = k - 1;
        break;
      end
      tick();
    end
    if (lat == 0 && out_valid[0]) lat = 40;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total_checks++;
    if (in_ready !== 3'b111) $display("FAIL reset_in_ready got %b want 111", in_ready);
    else passed_checks++;
    total_checks++;
    if (out_valid !== 3'b000) $display("FAIL reset_out_valid got %b want 000", out_valid);
    else passed_checks++;
    total_checks++;
    if (busy !== 3'b000) $display("FAIL reset_busy got %b want 000", busy);
    else passed_checks++;
    total_checks++;
    if (out_sum[0] !== '0) $display("FAIL reset_out_sum got %0d want 0", out_sum[0]);
    else passed_checks++;
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    in_data  = seq_vec();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total_checks++;
    if (in_ready[0] !== 1'b0 || busy[0] !== 1'b1)
      $display("FAIL basic_accept got in_ready=%b busy=%b want 0/1", in_ready[0], busy[0]);
    else passed_checks++;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid[0]) begin
        lat = k;
        break;
      end
    end
    total_checks++;
    if (lat != model_latency(2)) $display("FAIL basic_latency got %0d want %0d", lat, model_latency(2));
    else passed_checks++;
    total_checks++;
    if (out_sum[0] !== OW'(model_sum(seq_vec()))) $display("FAIL basic_sum got %0d want 36", out_sum[0]);
    else passed_checks++;
    tick();
    total_checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1)
      $display("FAIL basic_one_cycle got out_valid=%b in_ready=%b want 0/1", out_valid[0], in_ready[0]);
    else passed_checks++;
  endtask

  task automatic test_max();
    int lat;
    out_ready = 1'b1;
    send_and_wait(fill_vec(8'hFF), lat);
    total_checks++;
    if (out_valid[0] !== 1'b1 || out_sum[0] !== 11'd2040)
      $display("FAIL max_sum got valid=%b sum=%0d want 1/2040", out_valid[0], out_sum[0]);
    else passed_checks++;
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [OW-1:0] exp_sum;
    logic [NI*IW-1:0] v;
    int bad = 0;
    v = rand_vec();
    exp_sum = OW'(model_sum(v));
    out_ready = 1'b0;
    send_and_wait(v, lat);
    total_checks++;
    if (out_valid[0] !== 1'b1) $display("FAIL bp_reach_done got %b want 1", out_valid[0]);
    else passed_checks++;
    in_data  = rand_vec();
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid[0] !== 1'b1 || out_sum[0] !== exp_sum || in_ready[0] !== 1'b0) bad++;
    end
    total_checks++;
    if (bad != 0) $display("FAIL bp_stall_hold got %0d bad cycles want 0 (sum %0d exp %0d)", bad, out_sum[0], exp_sum);
    else passed_checks++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    total_checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0)
      $display("FAIL bp_release got valid=%b ready=%b busy=%b want 0/1/0", out_valid[0], in_ready[0], busy[0]);
    else passed_checks++;
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    in_data  = seq_vec();
    in_valid = 1'b1;
    tick();
    in_data = fill_vec(8'h10);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid[0]) begin
        lat = k;
        break;
      end
    end
    total_checks++;
    if (lat == 0 || out_sum[0] !== 11'd36) $display("FAIL b2b_first got lat=%0d sum=%0d want sum 36", lat, out_sum[0]);
    else passed_checks++;
    tick();
    total_checks++;
    if (in_ready[0] !== 1'b1) $display("FAIL b2b_idle got in_ready=%b want 1", in_ready[0]);
    else passed_checks++;
    tick();
    in_valid = 1'b0;
    total_checks++;
    if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0)
      $display("FAIL b2b_second_accept got busy=%b in_ready=%b want 1/0", busy[0], in_ready[0]);
    else passed_checks++;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid[0]) begin
        lat = k;
        break;
      end
    end
    total_checks++;
    if (lat != model_latency(2) || out_sum[0] !== OW'(model_sum(fill_vec(8'h10))))
      $display("FAIL b2b_second got lat=%0d sum=%0d want %0d/128", lat, out_sum[0], model_latency(2));
    else passed_checks++;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    logic [NI*IW-1:0] v;
    out_ready = 1'b1;
    in_data  = fill_vec(8'h55);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0)
      $display("FAIL rstmid_idle got ready=%b valid=%b busy=%b want 1/0/0", in_ready[0], out_valid[0], busy[0]);
    else passed_checks++;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid[0]) seen++;
    end
    total_checks++;
    if (seen != 0) $display("FAIL rstmid_no_result got %0d valid cycles want 0", seen);
    else passed_checks++;
    v = rand_vec();
    send_and_wait(v, lat);
    total_checks++;
    if (out_valid[0] !== 1'b1 || out_sum[0] !== OW'(model_sum(v)))
      $display("FAIL rstmid_fresh got valid=%b sum=%0d want 1/%0d", out_valid[0], out_sum[0], model_sum(v));
    else passed_checks++;
    tick();
  endtask

  task automatic test_param_sweep();
    logic [NI*IW-1:0] v;
    int lat [3];
    logic [OW-1:0] got [3];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int it = 0; it < 9; it++) begin
      v = (it == 0) ? seq_vec() : rand_vec();
      in_data  = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        lat[d] = 0;
        got[d] = '0;
      end
      for (int k = 1; k <= 20; k++) begin
        tick();
        for (int d = 0; d < 3; d++) begin
          if (out_valid[d] && lat[d] == 0) begin
            lat[d] = k;
            got[d] = out_sum[d];
          end
        end
      end
      for (int d = 0; d < 3; d++) begin
        total_checks++;
        if (lat[d] != model_latency(adders[d]) || got[d] !== OW'(model_sum(v)))
          $display("FAIL sweep_na%0d_it%0d got lat=%0d sum=%0d want lat=%0d sum=%0d",
                   adders[d], it, lat[d], got[d], model_latency(adders[d]), model_sum(v));
        else passed_checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_param_sweep();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
